// File: rtl/conveyor_writer.sv
// conveyor_writer: producer-side write port for the dual conveyor store
// (conveyor 0 = normal, conveyor 1 = interrupt).
//
// Issue reserves a slot by writing it as "not finished" through this block.
// Pipelines later complete tagged results into small per-producer FIFOs.
// A round-robin arbiter drains the FIFOs into one registered write port.
// Reservations always take priority over queued completions.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   reserve_*         issue-side reservation request; reserve_stall refuses it
//   prod_*            per-producer completion ports (valid/ready handshake)
//   wr_*              registered conveyor write port, entry = {finished, fault, word}
//   outstanding       pending reservations per conveyor, [c*(CAW+1) +: CAW+1]
//   protocol_error    sticky flag: completion arrived with nothing outstanding
module conveyor_writer #(
  parameter int unsigned WORD_WIDTH          = 32,
  parameter int unsigned CONVEYOR_ADDR_WIDTH = 4,
  parameter int unsigned FAULT_ADDR_WIDTH    = 3,
  parameter int unsigned NUM_PRODUCERS       = 2,
  parameter int unsigned FIFO_ADDR_WIDTH     = 1
) (
  input  logic                                               clk,
  input  logic                                               reset,
  input  logic                                               reserve_valid,
  input  logic                                               reserve_conveyor,
  input  logic [CONVEYOR_ADDR_WIDTH-1:0]                     reserve_slot,
  output logic                                               reserve_stall,
  input  logic [NUM_PRODUCERS-1:0]                           prod_valid,
  output logic [NUM_PRODUCERS-1:0]                           prod_ready,
  input  logic [NUM_PRODUCERS-1:0]                           prod_conveyor,
  input  logic [NUM_PRODUCERS*CONVEYOR_ADDR_WIDTH-1:0]       prod_slot,
  input  logic [NUM_PRODUCERS*FAULT_ADDR_WIDTH-1:0]          prod_fault,
  input  logic [NUM_PRODUCERS*WORD_WIDTH-1:0]                prod_data,
  output logic                                               wr_en,
  output logic                                               wr_conveyor,
  output logic [CONVEYOR_ADDR_WIDTH-1:0]                     wr_addr,
  output logic [FAULT_ADDR_WIDTH+WORD_WIDTH:0]               wr_entry,
  output logic [2*(CONVEYOR_ADDR_WIDTH+1)-1:0]               outstanding,
  output logic                                               protocol_error
);

  localparam int unsigned CAW     = CONVEYOR_ADDR_WIDTH;
  localparam int unsigned FAW     = FAULT_ADDR_WIDTH;
  localparam int unsigned WW      = WORD_WIDTH;
  localparam int unsigned NP      = NUM_PRODUCERS;
  localparam int unsigned FPW     = FIFO_ADDR_WIDTH;
  localparam int unsigned DEPTH   = 1 << FPW;
  localparam int unsigned CNT_W   = CAW + 1;
  localparam int unsigned ENTRY_W = 1 + FAW + WW;
  localparam int unsigned PL_W    = 1 + CAW + FAW + WW;  // {conveyor, slot, fault, data}
  localparam int unsigned RR_W    = (NP > 1) ? $clog2(NP) : 1;
  localparam int unsigned SIZE    = 1 << CAW;
  localparam logic [FAW-1:0] F_NONE = '0;

  // ---------------------------------------------------------------------------
  // Per-producer completion FIFOs
  // ---------------------------------------------------------------------------
  logic [PL_W-1:0]  fifo_mem_q [NP][DEPTH];
  logic [FPW-1:0]   wptr_q     [NP];
  logic [FPW-1:0]   rptr_q     [NP];
  logic [FPW:0]     count_q    [NP];

  logic [PL_W-1:0]  prod_payload [NP];
  logic [NP-1:0]    fifo_full;
  logic [NP-1:0]    fifo_empty;
  logic [NP-1:0]    push;
  logic [NP-1:0]    pop;

  always_comb begin
    for (int unsigned p = 0; p < NP; p++) begin
      prod_payload[p] = {prod_conveyor[p],
                         prod_slot[p*CAW +: CAW],
                         prod_fault[p*FAW +: FAW],
                         prod_data[p*WW +: WW]};
      fifo_full[p]    = (count_q[p] == (FPW+1)'(DEPTH));
      fifo_empty[p]   = (count_q[p] == '0);
    end
  end

  // Ready comes only from the registered fill level, so a full FIFO never
  // enqueues even when it is being drained in the same cycle.
  assign prod_ready = ~fifo_full & {NP{~reset}};
  assign push       = prod_valid & prod_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned p = 0; p < NP; p++) begin
        wptr_q[p]  <= '0;
        rptr_q[p]  <= '0;
        count_q[p] <= '0;
      end
    end else begin
      for (int unsigned p = 0; p < NP; p++) begin
        if (push[p]) wptr_q[p] <= wptr_q[p] + 1'b1;
        if (pop[p])  rptr_q[p] <= rptr_q[p] + 1'b1;
        if (push[p] && !pop[p]) begin
          count_q[p] <= count_q[p] + 1'b1;
        end else if (!push[p] && pop[p]) begin
          count_q[p] <= count_q[p] - 1'b1;
        end
      end
    end
  end

  // Storage needs no reset: pointers define what is valid.
  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < NP; p++) begin
      if (push[p]) fifo_mem_q[p][wptr_q[p]] <= prod_payload[p];
    end
  end

  // ---------------------------------------------------------------------------
  // Reservation acceptance
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] out_q [2];
  logic [CNT_W-1:0] out_d [2];
  logic             err_q, err_d;
  logic             res_accept;

  assign reserve_stall = (out_q[reserve_conveyor] == CNT_W'(SIZE - 1));
  assign res_accept    = reserve_valid & ~reserve_stall;

  // ---------------------------------------------------------------------------
  // Round-robin arbiter; an accepted reservation owns the write port.
  // ---------------------------------------------------------------------------
  logic [RR_W-1:0] rr_q, rr_d;
  logic            grant_valid;
  logic [RR_W-1:0] grant_idx;
  logic [PL_W-1:0] grant_payload;
  logic            g_conv;
  logic [CAW-1:0]  g_slot;
  logic [FAW-1:0]  g_fault;
  logic [WW-1:0]   g_data;

  always_comb begin
    int unsigned cand;
    cand        = 0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (!res_accept) begin
      for (int unsigned i = 0; i < NP; i++) begin
        cand = (32'(rr_q) + i) % NP;
        if (!grant_valid && !fifo_empty[cand]) begin
          grant_valid = 1'b1;
          grant_idx   = RR_W'(cand);
        end
      end
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < NP; p++) begin
      pop[p] = grant_valid && (32'(grant_idx) == p);
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (grant_valid) begin
      if (32'(grant_idx) == NP - 1) rr_d = '0;
      else                          rr_d = grant_idx + 1'b1;
    end
  end

  assign grant_payload = fifo_mem_q[grant_idx][rptr_q[grant_idx]];
  assign g_data        = grant_payload[WW-1:0];
  assign g_fault       = grant_payload[WW +: FAW];
  assign g_slot        = grant_payload[WW+FAW +: CAW];
  assign g_conv        = grant_payload[PL_W-1];

  // ---------------------------------------------------------------------------
  // Outstanding counters and sticky protocol error
  // ---------------------------------------------------------------------------
  always_comb begin
    out_d[0] = out_q[0];
    out_d[1] = out_q[1];
    err_d    = err_q;
    if (res_accept) begin
      out_d[reserve_conveyor] = out_q[reserve_conveyor] + 1'b1;
    end
    if (grant_valid) begin
      // A completion with nothing pending is still written, but flagged.
      if (out_d[g_conv] == '0) err_d = 1'b1;
      else                     out_d[g_conv] = out_d[g_conv] - 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered write port
  // ---------------------------------------------------------------------------
  logic               wr_en_q;
  logic               wr_conveyor_q;
  logic [CAW-1:0]     wr_addr_q;
  logic [ENTRY_W-1:0] wr_entry_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_q       <= 1'b0;
      wr_conveyor_q <= 1'b0;
      wr_addr_q     <= '0;
      wr_entry_q    <= '0;
      rr_q          <= '0;
      out_q[0]      <= '0;
      out_q[1]      <= '0;
      err_q         <= 1'b0;
    end else begin
      rr_q     <= rr_d;
      out_q[0] <= out_d[0];
      out_q[1] <= out_d[1];
      err_q    <= err_d;
      if (res_accept) begin
        wr_en_q       <= 1'b1;
        wr_conveyor_q <= reserve_conveyor;
        wr_addr_q     <= reserve_slot;
        wr_entry_q    <= {1'b0, F_NONE, {WW{1'b0}}};
      end else if (grant_valid) begin
        wr_en_q       <= 1'b1;
        wr_conveyor_q <= g_conv;
        wr_addr_q     <= g_slot;
        wr_entry_q    <= {1'b1, g_fault, g_data};
      end else begin
        wr_en_q       <= 1'b0;
        wr_conveyor_q <= 1'b0;
        wr_addr_q     <= '0;
        wr_entry_q    <= '0;
      end
    end
  end

  assign wr_en          = wr_en_q;
  assign wr_conveyor    = wr_conveyor_q;
  assign wr_addr        = wr_addr_q;
  assign wr_entry       = wr_entry_q;
  assign outstanding    = {out_q[1], out_q[0]};
  assign protocol_error = err_q;

endmodule
